// File: rtl/mem_data_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds the sequencer state encoding, requester ids and the access-error encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    localparam logic ERR_NONE       = 1'b0;
    localparam logic ERR_MISALIGNED = 1'b1;

    // Word-addressed memory: any nonzero byte offset is an error and suppresses the access.
    function automatic logic addr_err(input logic [1:0] byte_off);
        return (byte_off != 2'b00) ? ERR_MISALIGNED : ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_data_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On a tie the requester that did not win last time wins;
// last_grant only advances when the caller reports an accepted grant through en_i.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o    = 2'b00;
        gnt_id_o = REQ_CORE;
        last_d   = last_q;
        if (req_i[0] && req_i[1]) begin
            gnt_id_o = ~last_q;
        end else if (req_i[1]) begin
            gnt_id_o = REQ_LOADER;
        end
        if (|req_i) begin
            gnt_o = (gnt_id_o == REQ_LOADER) ? 2'b10 : 2'b01;
            if (en_i) begin
                last_d = gnt_id_o;
            end
        end
    end

    // Reset value makes requester 0 win the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= REQ_LOADER;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// Arbiter/sequencer in front of mem_data: IDLE grants one requester, MEM drives the port
// for one cycle and captures read data, RESP holds the response until it is consumed.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready; a
// response transfers on a rising edge where rsp_valid && rsp_ready. rsp_rdata/rsp_err
// are stable while rsp_valid is high and read 0 while it is low.
module mem_data_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 9,
    parameter int ADDR_W    = IDX_WIDTH + 2
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic              r0_req_we,
    input  logic [WIDTH-1:0]  r0_req_wdata,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [WIDTH-1:0]  r0_rsp_rdata,
    output logic              r0_rsp_err,

    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic              r1_req_we,
    input  logic [WIDTH-1:0]  r1_req_wdata,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [WIDTH-1:0]  r1_rsp_rdata,
    output logic              r1_rsp_err,

    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [WIDTH-1:0]  mem_write_data,
    output logic              mem_enable_write,
    input  logic [WIDTH-1:0]  mem_read_data,

    output state_t            dbg_state_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              id_q, id_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_id;
    logic       handshake;
    logic       owner_rsp_ready;
    logic       lat_err;

    // Requests are only visible to the arbiter while idle, so ready is zero in MEM/RESP.
    assign arb_req   = (state_q == IDLE && !rst_i) ? {r1_req_valid, r0_req_valid} : 2'b00;
    assign handshake = |arb_gnt;

    rr_arbiter2 u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (arb_req),
        .en_i     (handshake),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id)
    );

    assign lat_err         = addr_err(addr_q[1:0]);
    assign owner_rsp_ready = (id_q == REQ_LOADER) ? r1_rsp_ready : r0_rsp_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        id_d    = id_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    id_d    = arb_id;
                    addr_d  = (arb_id == REQ_LOADER) ? r1_req_addr  : r0_req_addr;
                    we_d    = (arb_id == REQ_LOADER) ? r1_req_we    : r0_req_we;
                    wdata_d = (arb_id == REQ_LOADER) ? r1_req_wdata : r0_req_wdata;
                    state_d = MEM;
                end
            end
            MEM: begin
                err_d   = lat_err;
                rdata_d = (!we_q && lat_err == ERR_NONE) ? mem_read_data : '0;
                state_d = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            id_q    <= REQ_CORE;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign r0_req_ready = arb_gnt[0];
    assign r1_req_ready = arb_gnt[1];

    assign r0_rsp_valid = (state_q == RESP) && (id_q == REQ_CORE);
    assign r1_rsp_valid = (state_q == RESP) && (id_q == REQ_LOADER);
    assign r0_rsp_rdata = r0_rsp_valid ? rdata_q : '0;
    assign r1_rsp_rdata = r1_rsp_valid ? rdata_q : '0;
    assign r0_rsp_err   = r0_rsp_valid & err_q;
    assign r1_rsp_err   = r1_rsp_valid & err_q;

    // Address and data simply hold outside MEM; only the write strobe is state-qualified.
    assign mem_access_addr  = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_enable_write = (state_q == MEM) && we_q && (lat_err == ERR_NONE);

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Randomised and directed bench for mem_data_arbiter with a transaction-level reference
// model, per-port expected-response queues and an independent response monitor.
module tb_mem_data_arbiter;
    import mem_arb_pkg::*;

    localparam int WIDTH     = 32;
    localparam int IDX_WIDTH = 9;
    localparam int ADDR_W    = IDX_WIDTH + 2;
    localparam int DEPTH     = 1 << IDX_WIDTH;

    logic clk = 1'b0;
    logic rst;

    logic              r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
    logic [ADDR_W-1:0] r0_req_addr;
    logic [WIDTH-1:0]  r0_req_wdata, r0_rsp_rdata;
    logic              r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
    logic [ADDR_W-1:0] r1_req_addr;
    logic [WIDTH-1:0]  r1_req_wdata, r1_rsp_rdata;
    logic [ADDR_W-1:0] mem_access_addr;
    logic [WIDTH-1:0]  mem_write_data, mem_read_data;
    logic              mem_enable_write;
    state_t            dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH:0]   exp_q0[$];
    logic [WIDTH:0]   exp_q1[$];
    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_data_arbiter #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
        .r0_req_we(r0_req_we), .r0_req_wdata(r0_req_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
        .r1_req_we(r1_req_we), .r1_req_wdata(r1_req_wdata), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_enable_write(mem_enable_write), .mem_read_data(mem_read_data),
        .dbg_state_o(dbg_state)
    );

    // Behavioural mem_data: asynchronous read, synchronous write.
    assign mem_read_data = mem[mem_access_addr[ADDR_W-1:2]];
    always @(posedge clk) begin
        if (mem_enable_write) mem[mem_access_addr[ADDR_W-1:2]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, accept -> memory cycle -> held response.
    int                m_phase;
    logic              m_last, m_owner, m_we, m_mis, e0, e1;
    logic [ADDR_W-1:0] m_addr;
    logic [WIDTH-1:0]  m_wdata;
    logic [WIDTH:0]    m_rsp;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_phase = 0;
            m_last  = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    e0 = r0_req_valid && (!r1_req_valid || m_last == 1'b1);
                    e1 = r1_req_valid && (!r0_req_valid || m_last == 1'b0);
                    chk("r0_req_ready", r0_req_ready, e0);
                    chk("r1_req_ready", r1_req_ready, e1);
                    chk("idle_no_write", mem_enable_write, 0);
                    if (e0 || e1) begin
                        m_owner = e1;
                        m_last  = e1;
                        m_addr  = e1 ? r1_req_addr  : r0_req_addr;
                        m_we    = e1 ? r1_req_we    : r0_req_we;
                        m_wdata = e1 ? r1_req_wdata : r0_req_wdata;
                        m_mis   = (m_addr % 4) != 0;
                        if (m_mis)     m_rsp = {1'b1, {WIDTH{1'b0}}};
                        else if (m_we) m_rsp = '0;
                        else           m_rsp = {1'b0, ref_mem[m_addr / 4]};
                        if (m_owner) exp_q1.push_back(m_rsp);
                        else         exp_q0.push_back(m_rsp);
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("mem_req_ready", {r1_req_ready, r0_req_ready}, 0);
                    chk("mem_enable_write", mem_enable_write, m_we && !m_mis);
                    chk("mem_access_addr", mem_access_addr, m_addr);
                    if (m_we) chk("mem_write_data", mem_write_data, m_wdata);
                    if (m_we && !m_mis) ref_mem[m_addr / 4] = m_wdata;
                    m_phase = 2;
                end
                default: begin
                    chk("resp_req_ready", {r1_req_ready, r0_req_ready}, 0);
                    chk("resp_no_write", mem_enable_write, 0);
                    chk("rsp_valid_ports", {r1_rsp_valid, r0_rsp_valid}, m_owner ? 2'b10 : 2'b01);
                    if (m_owner ? r1_rsp_ready : r0_rsp_ready) m_phase = 0;
                end
            endcase
        end
    end

    // Monitor: compares every presented response against the head of its port's queue.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (r0_rsp_valid) begin
                if (exp_q0.size() == 0) chk("r0_unexpected_rsp", r0_rsp_valid, 0);
                else begin
                    chk("r0_rsp", {r0_rsp_err, r0_rsp_rdata}, exp_q0[0]);
                    if (r0_rsp_ready) void'(exp_q0.pop_front());
                end
            end else chk("r0_rsp_quiet", {r0_rsp_err, r0_rsp_rdata}, 0);
            if (r1_rsp_valid) begin
                if (exp_q1.size() == 0) chk("r1_unexpected_rsp", r1_rsp_valid, 0);
                else begin
                    chk("r1_rsp", {r1_rsp_err, r1_rsp_rdata}, exp_q1[0]);
                    if (r1_rsp_ready) void'(exp_q1.pop_front());
                end
            end else chk("r1_rsp_quiet", {r1_rsp_err, r1_rsp_rdata}, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic [ADDR_W-1:0] a,
                           input logic w, input logic [WIDTH-1:0] d);
        if (port == 0) begin
            r0_req_valid = v; r0_req_addr = a; r0_req_we = w; r0_req_wdata = d;
        end else begin
            r1_req_valid = v; r1_req_addr = a; r1_req_we = w; r1_req_wdata = d;
        end
    endtask

    // Holds a request until accepted (bounded), then drops valid just after the edge.
    task automatic issue(input int port, input logic [ADDR_W-1:0] a, input logic w,
                         input logic [WIDTH-1:0] d);
        logic got;
        got = 1'b0;
        set_req(port, 1'b1, a, w, d);
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? r0_req_ready : r1_req_ready;
        end
        chk("issue_accepted", got, 1);
        tick();
        set_req(port, 1'b0, a, w, d);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, {r1_req_ready, r0_req_ready}, 0);
        chk({tag, "_rsp_valid"}, {r1_rsp_valid, r0_rsp_valid}, 0);
        chk({tag, "_rsp_err"}, {r1_rsp_err, r0_rsp_err}, 0);
        chk({tag, "_rsp_rdata"}, {r1_rsp_rdata, r0_rsp_rdata}, 0);
        chk({tag, "_mem_we"}, mem_enable_write, 0);
        chk({tag, "_mem_addr"}, mem_access_addr, 0);
        chk({tag, "_mem_wdata"}, mem_write_data, 0);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [IDX_WIDTH-1:0] idx;
        logic [1:0]           off;
        idx = IDX_WIDTH'($urandom_range(0, 15));
        off = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return {idx, off};
    endfunction

    initial begin
        logic [WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        rst = 1'b1;
        set_req(0, 1'b0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, 1'b0, '0);
        r0_rsp_ready = 1'b1;
        r1_rsp_ready = 1'b1;
        #2;
        check_outputs_zero("reset");
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single write then read-back on r0.
        issue(0, 11'h010, 1'b1, 32'hDEADBEEF);
        repeat (3) tick();
        issue(0, 11'h010, 1'b0, '0);
        repeat (3) tick();

        // Both requesters continuously valid: strict alternation.
        set_req(0, 1'b1, 11'h004, 1'b0, '0);
        set_req(1, 1'b1, 11'h008, 1'b0, '0);
        repeat (12) tick();
        set_req(0, 1'b0, 11'h004, 1'b0, '0);
        set_req(1, 1'b0, 11'h008, 1'b0, '0);
        repeat (4) tick();

        // Misaligned write on r1 must leave memory untouched.
        issue(1, 11'h013, 1'b1, 32'h12345678);
        repeat (3) tick();
        issue(0, 11'h010, 1'b0, '0);
        repeat (3) tick();

        // Response back-pressure with a competing request waiting.
        r0_rsp_ready = 1'b0;
        issue(0, 11'h004, 1'b0, '0);
        set_req(1, 1'b1, 11'h008, 1'b0, '0);
        repeat (6) tick();
        r0_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("next_grant_after_rsp", r1_req_ready, 1);
        tick();
        set_req(1, 1'b0, 11'h008, 1'b0, '0);
        repeat (4) tick();

        // Asynchronous reset while the memory cycle is in progress.
        issue(0, 11'h020, 1'b1, 32'hCAFEF00D);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_mem");
        repeat (2) tick();
        rst = 1'b0;
        set_req(0, 1'b1, 11'h020, 1'b0, '0);
        set_req(1, 1'b1, 11'h024, 1'b0, '0);
        @(negedge clk);
        chk("post_reset_first_grant", {r1_req_ready, r0_req_ready}, 2'b01);
        repeat (8) tick();
        set_req(0, 1'b0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, 1'b0, '0);
        repeat (4) tick();

        // Random traffic.
        repeat (400) begin
            set_req(0, 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            set_req(1, 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            r0_rsp_ready = ($urandom_range(0, 3) != 0);
            r1_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        set_req(0, 1'b0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, 1'b0, '0);
        r0_rsp_ready = 1'b1;
        r1_rsp_ready = 1'b1;
        repeat (10) tick();
        chk("q0_drained", exp_q0.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
